// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux port arbiter.
// Used by the top-level arbiter and its rotating priority picker.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Converts a 2-bit requester index to its one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        case (idx)
            2'd0:    vec = 4'b0001;
            2'd1:    vec = 4'b0010;
            2'd2:    vec = 4'b0100;
            2'd3:    vec = 4'b1000;
            default: vec = 4'b0000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/mux_port_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first unmasked request after 'last'.
// Purely combinational; it serves both the idle grant and the handover.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [SEL_W-1:0] last,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] eff_s;
    logic [SEL_W-1:0] cand_s;

    // Walk candidates from last+1 with wrap; the first hit wins.
    always_comb begin
        eff_s  = req & ~mask;
        valid  = 1'b0;
        idx    = {SEL_W{1'b0}};
        cand_s = {SEL_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = last + SEL_W'(i + 1);
            idx    = (!valid && eff_s[cand_s]) ? cand_s : idx;
            valid  = valid | eff_s[cand_s];
        end
    end

endmodule

// File: rtl/mux_port_arbiter.sv
// Round-robin owner of the shared 4:1 datapath mux select: one-hot grants,
// hold-until-done handshake, and forced release after MAX_HOLD cycles.
module mux_port_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout,
    output logic [SEL_W-1:0] timeout_id
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [SEL_W-1:0] last_r, last_n;
    logic [N_REQ-1:0] gnt_r, gnt_n;
    logic [SEL_W-1:0] sel_r, sel_n;
    logic             busy_r;
    logic             timeout_r, timeout_n;
    logic [SEL_W-1:0] timeout_id_r, timeout_id_n;

    logic [N_REQ-1:0] pick_mask_s;
    logic [SEL_W-1:0] pick_last_s;
    logic             pick_valid_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             limit_s;
    logic             release_s;
    logic             timeout_s;

    // While owning, the current owner (sel) is masked so it cannot win again.
    always_comb begin
        if (state_r == OWN) begin
            pick_mask_s = onehot2(sel_r);
            pick_last_s = sel_r;
        end else begin
            pick_mask_s = {N_REQ{1'b0}};
            pick_last_s = last_r;
        end
    end

    rr_pick u_pick (
        .req   (req),
        .mask  (pick_mask_s),
        .last  (pick_last_s),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Release conditions; timeout only when the limit alone forces release.
    always_comb begin
        limit_s   = (cnt_r == LIMIT);
        release_s = (state_r == OWN) && (done || !req[sel_r] || limit_s);
        timeout_s = release_s && !done && req[sel_r] && limit_s;
    end

    // Next-state, grant and counter logic.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        last_n       = last_r;
        gnt_n        = gnt_r;
        sel_n        = sel_r;
        timeout_n    = 1'b0;
        timeout_id_n = timeout_id_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    gnt_n   = onehot2(pick_idx_s);
                    sel_n   = pick_idx_s;
                    cnt_n   = {CNT_W{1'b0}};
                    state_n = OWN;
                end else begin
                    gnt_n = {N_REQ{1'b0}};
                end
            end
            OWN: begin
                if (release_s) begin
                    last_n    = sel_r;
                    timeout_n = timeout_s;
                    if (timeout_s) begin
                        timeout_id_n = sel_r;
                    end else begin
                        timeout_id_n = timeout_id_r;
                    end
                    if (pick_valid_s) begin
                        gnt_n = onehot2(pick_idx_s);
                        sel_n = pick_idx_s;
                        cnt_n = {CNT_W{1'b0}};
                    end else begin
                        gnt_n   = {N_REQ{1'b0}};
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
                end
            end
            default: begin
                gnt_n   = {N_REQ{1'b0}};
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any grant without a timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            last_r       <= 2'd3;
            gnt_r        <= {N_REQ{1'b0}};
            sel_r        <= {SEL_W{1'b0}};
            busy_r       <= 1'b0;
            timeout_r    <= 1'b0;
            timeout_id_r <= {SEL_W{1'b0}};
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            last_r       <= last_n;
            gnt_r        <= gnt_n;
            sel_r        <= sel_n;
            busy_r       <= |gnt_n;
            timeout_r    <= timeout_n;
            timeout_id_r <= timeout_id_n;
        end
    end

    assign gnt        = gnt_r;
    assign sel        = sel_r;
    assign busy       = busy_r;
    assign timeout    = timeout_r;
    assign timeout_id = timeout_id_r;

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Directed bench for mux_port_arbiter: reset, rotation, timeout, handover,
// request abandonment and mid-grant reset, each with hand-computed results.
module tb_mux_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
    logic [1:0] timeout_id;

    int total;
    int bad;

    mux_port_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .sel        (sel),
        .busy       (busy),
        .timeout    (timeout),
        .timeout_id (timeout_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_timeout_id", 32'(timeout_id), 32'h0);

        // Test 1: single grant and done release
        req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_sel", 32'(sel), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        req  = 4'b0000;
        done = 1'b1;
        tick();
        chk("t1_rel_gnt", 32'(gnt), 32'h0);
        chk("t1_rel_busy", 32'(busy), 32'h0);
        chk("t1_rel_sel", 32'(sel), 32'h0);
        // done while idle is ignored
        tick();
        chk("idle_done_gnt", 32'(gnt), 32'h0);
        chk("idle_done_busy", 32'(busy), 32'h0);
        done = 1'b0;

        // Test 2: full rotation with zero bubbles
        do_reset();
        req = 4'b1111;
        tick();
        chk("t2_first_gnt", 32'(gnt), 32'h1);
        chk("t2_first_sel", 32'(sel), 32'h0);
        done = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_s = 2'(i);
            exp_g = 4'b0001 << exp_s;
            chk("t2_rot_gnt", 32'(gnt), 32'(exp_g));
            chk("t2_rot_sel", 32'(sel), 32'(exp_s));
            chk("t2_rot_busy", 32'(busy), 32'h1);
        end
        req = 4'b0000;
        tick();
        chk("t2_end_gnt", 32'(gnt), 32'h0);
        done = 1'b0;

        // Test 3: forced release after 16 cycles, then re-grant after one idle cycle
        req = 4'b0100;
        tick();
        chk("t3_gnt", 32'(gnt), 32'h4);
        chk("t3_sel", 32'(sel), 32'h2);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t3_hold_gnt", 32'(gnt), 32'h4);
            chk("t3_hold_timeout", 32'(timeout), 32'h0);
        end
        tick();
        chk("t3_to_gnt", 32'(gnt), 32'h0);
        chk("t3_to_busy", 32'(busy), 32'h0);
        chk("t3_to_pulse", 32'(timeout), 32'h1);
        chk("t3_to_id", 32'(timeout_id), 32'h2);
        tick();
        chk("t3_regrant_gnt", 32'(gnt), 32'h4);
        chk("t3_pulse_end", 32'(timeout), 32'h0);

        // Test 4: done on the final counter cycle wins over timeout
        do_reset();
        req = 4'b0110;
        tick();
        chk("t4_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("t4_still_gnt", 32'(gnt), 32'h2);
        done = 1'b1;
        tick();
        chk("t4_hand_gnt", 32'(gnt), 32'h4);
        chk("t4_hand_sel", 32'(sel), 32'h2);
        chk("t4_no_timeout", 32'(timeout), 32'h0);
        done = 1'b0;

        // Test 5: owner 3 abandons, wrap to requester 0
        do_reset();
        req = 4'b1000;
        tick();
        chk("t5_gnt", 32'(gnt), 32'h8);
        chk("t5_sel", 32'(sel), 32'h3);
        tick();
        req = 4'b0011;
        tick();
        chk("t5_wrap_gnt", 32'(gnt), 32'h1);
        chk("t5_wrap_sel", 32'(sel), 32'h0);
        chk("t5_no_timeout", 32'(timeout), 32'h0);

        // Test 6: reset mid-grant, then re-grant
        req = 4'b1000;
        tick();
        chk("t6_gnt", 32'(gnt), 32'h8);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_sel", 32'(sel), 32'h0);
        chk("t6_rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("t6_regrant_gnt", 32'(gnt), 32'h8);
        chk("t6_regrant_sel", 32'(sel), 32'h3);
        chk("t6_regrant_busy", 32'(busy), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_port_arbiter.md
Name: mux_port_arbiter

Overview:
Round-robin arbiter that shares one 32-bit datapath resource (the 4:1 select mux feeding a shared memory/ALU port) between up to four requesters. It owns the mux select lines, issues one-hot grants with a hold-until-done handshake, and enforces a maximum hold time with forced release. It sits between the multi-source datapath control and the 2-bit select input of the shared 4:1 mux.

Parameters:
N_REQ, 4, number of requesters; fixed at 4 to match a 2-bit mux select (other values unsupported).
MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 2..255.
CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
req  input  4  per-requester request, level; held high until done or until the requester abandons.
done  input  1  owner signals its transaction is complete this cycle.
gnt  output  4  one-hot grant, registered; all-zero when idle.
sel  output  2  mux select, registered; index of current or last owner.
busy  output  1  high while any grant is active.
timeout  output  1  one-cycle pulse when a grant is forcibly released.
timeout_id  output  2  index of the requester released by timeout; valid with timeout.

Behaviour:
- Reset (rst_n low at a clock edge): gnt=0, sel=0, busy=0, timeout=0, timeout_id=0, hold counter=0, last-owner pointer=3, state=IDLE. Reset mid-grant drops the grant on that same edge with no timeout pulse.
- Arbitration: search order starts at (last+1) mod 4 and wraps. The first asserted req wins. Example: last=1 and req=1011 gives owner 3.
- States: IDLE, OWN.
- IDLE:
  - If req is nonzero, on the next edge: gnt=onehot(win), sel=win, busy=1, counter=0, state=OWN. Latency from req to gnt is 1 cycle.
  - If req is zero: gnt=0, busy=0, sel holds its previous value.
- OWN, with owner k:
  - The counter increments each cycle, saturating.
  - Release occurs when done=1, req[k]=0, or the counter reaches MAX_HOLD-1.
  - On release: last=k. Arbitration runs over req with bit k masked. If any other requester wins, the grant hands over on the same edge (gnt, sel updated, counter=0, state stays OWN; zero bubble cycles). Otherwise gnt=0, busy=0, state=IDLE.
  - k is never re-granted back-to-back while another requester is pending. If only k requests, it is re-granted after one idle cycle.
- Timeout: if release is caused solely by the counter limit (done=0 and req[k]=1), then timeout=1 and timeout_id=k for exactly one cycle, aligned with the edge that removes the grant. If done and the limit coincide, done wins and no timeout is raised.
- Invariants:
  - gnt is always one-hot or zero.
  - busy equals the OR of gnt.
  - sel equals the gnt index whenever busy=1.
  - sel changes only on a grant edge.
  - done asserted while busy=0 is ignored.
- Counter width: CNT_W bits, unsigned, compared against MAX_HOLD-1 truncated to CNT_W.

Decomposition:
- Package mux_arb_pkg: typedef state_t {IDLE, OWN}; constants N_REQ=4 and SEL_W=2; function onehot2 (index to 4-bit one-hot).
- One combinational sub-module, rr_pick:
  - Inputs: req[3:0], mask[3:0], last[1:0].
  - Outputs: valid, idx[1:0].
  - Used for both the IDLE grant and the handover grant.
- All state, counter, and outputs live in mux_port_arbiter.

Test Plan:
1. Reset then req=0001 → gnt=0001, sel=0, busy=1 one cycle later. Pulse done → gnt=0000, busy=0, sel stays 0.
2. req=1111 held, done pulsed each grant → grant order 0,1,2,3,0 with zero idle cycles between grants; sel tracks 0,1,2,3,0.
3. req=0100 only, done never asserted, MAX_HOLD=16 → gnt=0100 for exactly 16 cycles, then timeout=1 with timeout_id=2 for one cycle, gnt=0. One idle cycle later it is re-granted.
4. Owner 1 with req=0110 and done asserted on the counter's final cycle → handover to 2, timeout stays 0.
5. Owner 3 drops req[3] mid-grant with req=0011 pending → next edge gnt=0001 (wrap from last=3 to 0), no timeout.
6. rst_n low for one edge during OWN with req=1000 → gnt=0, busy=0, sel=0, no timeout. After rst_n returns high, req=1000 is granted next cycle.
